// File: rtl/buffer_mac_reader_if.sv
// Bundles the run-control, buffer-read and result handshake signals of the dot-product reader.
interface buffer_mac_reader_if #(
    parameter int DataWidth   = 8,
    parameter int BufferWidth = 2,
    parameter int AccWidth    = 2 * DataWidth + BufferWidth + 1
);
    logic                   Start;
    logic [BufferWidth-1:0] Base1;
    logic [BufferWidth-1:0] Base2;
    logic [BufferWidth:0]   Len;
    logic [BufferWidth-1:0] R_Addr1;
    logic [BufferWidth-1:0] R_Addr2;
    logic [DataWidth-1:0]   DataIn1;
    logic [DataWidth-1:0]   DataIn2;
    logic                   Busy;
    logic [AccWidth-1:0]    Result;
    logic                   ResultValid;
    logic                   ResultReady;

    modport master (
        output Start, Base1, Base2, Len, DataIn1, DataIn2, ResultReady,
        input  R_Addr1, R_Addr2, Busy, Result, ResultValid
    );

    modport slave (
        input  Start, Base1, Base2, Len, DataIn1, DataIn2, ResultReady,
        output R_Addr1, R_Addr2, Busy, Result, ResultValid
    );
endinterface

// File: rtl/buffer_mac_reader.sv
// Reads two wrapping operand streams from a dual-port buffer and accumulates their
// unsigned dot product, presenting the sum through a valid/ready result handshake.
module buffer_mac_reader #(
    parameter int DataWidth   = 8,
    parameter int BufferSize  = 4,
    parameter int BufferWidth = 2,
    parameter int AccWidth    = 2 * DataWidth + BufferWidth + 1
) (
    input logic                 clk,
    input logic                 rst,
    buffer_mac_reader_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

    state_t                 state;
    logic [AccWidth-1:0]    acc;
    logic [AccWidth-1:0]    acc_sum;
    logic [BufferWidth:0]   cnt;
    logic [BufferWidth:0]   cnt_nxt;
    logic [BufferWidth:0]   len_q;
    logic [BufferWidth-1:0] addr1;
    logic [BufferWidth-1:0] addr2;
    logic [AccWidth-1:0]    result;
    logic                   valid;
    logic                   busy;

    // Full-precision unsigned product, zero-extended to the accumulator width.
    function automatic logic [AccWidth-1:0] widen_product(
        input logic [DataWidth-1:0] a,
        input logic [DataWidth-1:0] b
    );
        logic [2*DataWidth-1:0] p;
        p = {{DataWidth{1'b0}}, a} * {{DataWidth{1'b0}}, b};
        return {{(AccWidth - 2 * DataWidth){1'b0}}, p};
    endfunction

    assign acc_sum = acc + widen_product(bus.DataIn1, bus.DataIn2);
    assign cnt_nxt = cnt + (BufferWidth + 1)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            len_q  <= '0;
            addr1  <= '0;
            addr2  <= '0;
            result <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        len_q <= bus.Len;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        if (bus.Len == '0) begin
                            result <= '0;
                            valid  <= 1'b1;
                            state  <= DONE;
                        end else begin
                            addr1 <= bus.Base1;
                            addr2 <= bus.Base2;
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    acc <= acc_sum;
                    cnt <= cnt_nxt;
                    // Final pair: publish the sum and park the read ports at 0.
                    if (cnt_nxt == len_q) begin
                        result <= acc_sum;
                        valid  <= 1'b1;
                        addr1  <= '0;
                        addr2  <= '0;
                        state  <= DONE;
                    end else begin
                        addr1 <= addr1 + BufferWidth'(1);
                        addr2 <= addr2 + BufferWidth'(1);
                    end
                end
                DONE: begin
                    if (bus.ResultReady) begin
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.R_Addr1     = addr1;
    assign bus.R_Addr2     = addr2;
    assign bus.Busy        = busy;
    assign bus.Result      = result;
    assign bus.ResultValid = valid;
endmodule

// File: tb/tb_buffer_mac_reader.sv
// Directed bench for buffer_mac_reader with a result scoreboard fed at run launch.
module tb_buffer_mac_reader;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [18:0] sb[$];
    logic [7:0]  mem [4];

    buffer_mac_reader_if bus ();

    buffer_mac_reader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.DataIn1 = mem[bus.R_Addr1];
    assign bus.DataIn2 = mem[bus.R_Addr2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Result monitor: pops the scoreboard on every accepted result.
    always @(negedge clk) begin
        #2;
        if (!rst && bus.ResultValid === 1'b1 && bus.ResultReady === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got %0d expected none", bus.Result);
            end else begin
                chk("result", 32'(bus.Result), 32'(sb.pop_front()));
            end
        end
    end

    task automatic run_dot(input logic [1:0] b1, input logic [1:0] b2, input logic [2:0] len,
                           input logic [18:0] exp, input int hold);
        logic [1:0] a1;
        logic [1:0] a2;
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Base1 = b1;
        bus.Base2 = b2;
        bus.Len   = len;
        bus.ResultReady = (hold == 0);
        sb.push_back(exp);
        @(negedge clk);
        bus.Start = 1'b0;
        bus.Base1 = b1 + 2'd1;
        bus.Base2 = b2 + 2'd2;
        bus.Len   = len + 3'd1;
        for (int i = 0; i < int'(len); i++) begin
            a1 = b1 + 2'(i);
            a2 = b2 + 2'(i);
            chk("busy_run", 32'(bus.Busy), 32'd1);
            chk("valid_early", 32'(bus.ResultValid), 32'd0);
            chk("raddr1", 32'(bus.R_Addr1), 32'(a1));
            chk("raddr2", 32'(bus.R_Addr2), 32'(a2));
            @(negedge clk);
        end
        chk("valid_done", 32'(bus.ResultValid), 32'd1);
        chk("busy_done", 32'(bus.Busy), 32'd1);
        if (len == 3'd0) begin
            chk("raddr1_len0", 32'(bus.R_Addr1), 32'd0);
            chk("raddr2_len0", 32'(bus.R_Addr2), 32'd0);
        end
        for (int j = 0; j < hold; j++) begin
            bus.Start = (j == 1);
            @(negedge clk);
            chk("hold_result", 32'(bus.Result), 32'(exp));
            chk("hold_busy", 32'(bus.Busy), 32'd1);
            chk("hold_valid", 32'(bus.ResultValid), 32'd1);
        end
        if (hold > 0) begin
            bus.ResultReady = 1'b1;
            bus.Start = 1'b1;
        end
        @(negedge clk);
        bus.Start = 1'b0;
        chk("idle_busy", 32'(bus.Busy), 32'd0);
        chk("idle_valid", 32'(bus.ResultValid), 32'd0);
        chk("idle_result_held", 32'(bus.Result), 32'(exp));
        chk("idle_raddr1", 32'(bus.R_Addr1), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.Start = 1'b0;
        bus.Base1 = '0;
        bus.Base2 = '0;
        bus.Len   = '0;
        bus.ResultReady = 1'b0;
        mem = '{8'd3, 8'd5, 8'd7, 8'd9};
        #2;
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_valid", 32'(bus.ResultValid), 32'd0);
        chk("rst_result", 32'(bus.Result), 32'd0);
        chk("rst_raddr1", 32'(bus.R_Addr1), 32'd0);
        chk("rst_raddr2", 32'(bus.R_Addr2), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_dot(2'd0, 2'd1, 3'd3, 19'd113, 0);
        run_dot(2'd3, 2'd0, 3'd2, 19'd42, 0);
        run_dot(2'd1, 2'd2, 3'd0, 19'd0, 0);
        run_dot(2'd0, 2'd1, 3'd3, 19'd113, 3);
        mem = '{8'd255, 8'd255, 8'd255, 8'd255};
        run_dot(2'd0, 2'd0, 3'd7, 19'd455175, 0);
        mem = '{8'd3, 8'd5, 8'd7, 8'd9};

        // Abort a run after its first accumulate edge.
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Base1 = 2'd0;
        bus.Base2 = 2'd1;
        bus.Len   = 3'd3;
        bus.ResultReady = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.Busy), 32'd0);
        chk("abort_valid", 32'(bus.ResultValid), 32'd0);
        chk("abort_result", 32'(bus.Result), 32'd0);
        chk("abort_raddr1", 32'(bus.R_Addr1), 32'd0);
        chk("abort_raddr2", 32'(bus.R_Addr2), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_partial", 32'(bus.ResultValid), 32'd0);
        run_dot(2'd0, 2'd1, 3'd3, 19'd113, 0);

        @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
